// File: rtl/invsqrt_sched.sv
// invsqrt_sched: round-robin scheduler sharing one InvertSQRoot pipeline among NUM_REQ requesters.
// Define INVSQ_SCHED_CHECK_EN to add the sticky err output flagging a tail result without DataValid.
module invsqrt_sched #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 8,
    parameter int TAG_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    res_valid,
    output logic [31:0]           res_data,
    input  logic [NUM_REQ-1:0]    res_ready,
    output logic                  sq_ce,
    output logic [31:0]           sq_data_in,
    input  logic [31:0]           sq_data_out,
    input  logic                  sq_data_valid,
    output logic [3:0]            inflight,
    output logic                  idle
`ifdef INVSQ_SCHED_CHECK_EN
    ,
    output logic                  err
`endif
);

    logic [LATENCY-1:0] v_q, v_d;
    logic [TAG_W-1:0]   tag_q [LATENCY];
    logic [TAG_W-1:0]   tag_d [LATENCY];
    logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [3:0]         inflight_q, inflight_d;
    logic               tail_v, tail_rdy, res_fire, gnt_any;
    logic [TAG_W-1:0]   tail_tag, gnt_idx;

    assign tail_v   = v_q[LATENCY-1];
    assign tail_tag = tag_q[LATENCY-1];

    always_comb begin
        tail_rdy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            tail_rdy = (tail_tag == TAG_W'(i)) ? res_ready[i] : tail_rdy;
        sq_ce    = ~(tail_v & ~tail_rdy);
        res_fire = tail_v & tail_rdy;
    end

    // Lowest distance from rr_ptr wins: later (smaller k) matches overwrite earlier ones.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            for (int i = 0; i < NUM_REQ; i++)
                if (req_valid[i] && ((int'(rr_ptr_q) + k) % NUM_REQ) == i) begin
                    gnt_any = 1'b1;
                    gnt_idx = TAG_W'(i);
                end
        gnt_any = gnt_any & sq_ce & ~rst;
    end

    always_comb begin
        req_ready  = '0;
        res_valid  = '0;
        sq_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = gnt_any & (gnt_idx == TAG_W'(i));
            res_valid[i] = tail_v & (tail_tag == TAG_W'(i));
            sq_data_in   = req_ready[i] ? req_data[32*i +: 32] : sq_data_in;
        end
    end

    assign res_data = sq_data_out;
    assign inflight = inflight_q;
    assign idle     = (inflight_q == 4'd0) & ~|req_valid;

    always_comb begin
        v_d   = v_q;
        tag_d = tag_q;
        if (sq_ce) begin
            for (int k = LATENCY - 1; k > 0; k--) begin
                v_d[k]   = v_q[k-1];
                tag_d[k] = tag_q[k-1];
            end
            v_d[0]   = gnt_any;
            tag_d[0] = gnt_idx;
        end
        rr_ptr_d   = !gnt_any ? rr_ptr_q :
                     (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        inflight_d = (gnt_any & ~res_fire & (inflight_q < 4'(LATENCY))) ? inflight_q + 4'd1 :
                     (~gnt_any & res_fire & (inflight_q != 4'd0)) ? inflight_q - 4'd1 : inflight_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q        <= '0;
            rr_ptr_q   <= '0;
            inflight_q <= '0;
            for (int k = 0; k < LATENCY; k++)
                tag_q[k] <= '0;
        end else begin
            v_q        <= v_d;
            tag_q      <= tag_d;
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef INVSQ_SCHED_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (sq_ce & tail_v & ~sq_data_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_sq_data_valid;
    assign unused_sq_data_valid = sq_data_valid;
`endif

endmodule

// File: tb/tb_invsqrt_sched.sv
// tb_invsqrt_sched: randomized scoreboard bench for invsqrt_sched with a stub pipeline (DataIn+1, LATENCY ce-edges).
// The reference model is an in-order FIFO of outstanding operations aged in ce-enabled edges.
module tb_invsqrt_sched;
    localparam int N = 4;
    localparam int L = 8;

    typedef struct {
        int          owner;
        logic [31:0] data;
        int          age;
    } ent_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid, req_ready, res_valid, res_ready;
    logic [32*N-1:0] req_data;
    logic [31:0]    res_data, sq_data_in, sq_data_out;
    logic           sq_ce, sq_data_valid, idle;
    logic [3:0]     inflight;
`ifdef INVSQ_SCHED_CHECK_EN
    logic           err;
`endif

    logic [31:0]    sd [L];
    logic [L-1:0]   sv = '0;
    logic           kill = 1'b0;

    logic [N-1:0]   taken = '0;
    logic [N-1:0]   mask = '0;
    int             p_req = 0;
    int             p_rdy = 100;
    bit             auto_on = 1'b0;
    int             cyc = 0;
    int             stall_cnt = 0;
    int             ptr = 0;
    int             vec = 0;
    int             errs = 0;
    int             g_cyc[$], g_own[$], r_cyc[$];
    logic [31:0]    r_dat[$];
    ent_t           mq[$];

    always #5 clk = ~clk;

    invsqrt_sched #(.NUM_REQ(N), .LATENCY(L), .TAG_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .sq_ce(sq_ce), .sq_data_in(sq_data_in), .sq_data_out(sq_data_out),
        .sq_data_valid(sq_data_valid), .inflight(inflight), .idle(idle)
`ifdef INVSQ_SCHED_CHECK_EN
        , .err(err)
`endif
    );

    // Stub InvertSQRoot: DataOut = DataIn + 1, LATENCY ce-enabled edges deep.
    always @(posedge clk) begin
        if (sq_ce) begin
            for (int k = L - 1; k > 0; k--) sd[k] <= sd[k-1];
            sd[0] <= sq_data_in + 32'd1;
            sv    <= {sv[L-2:0], |(req_valid & req_ready)};
        end
    end
    assign sq_data_out   = sd[L-1];
    assign sq_data_valid = sv[L-1] & ~kill;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        bit          present, exp_ce;
        int          own, gnt;
        logic [N-1:0] exp_rv, exp_rr;
        logic [31:0] exp_in;
        forever begin
            @(negedge clk);
            cyc++;
            stall_cnt += int'(!sq_ce);
            if (rst) begin
                chk("rst_res_valid", 32'(res_valid), 32'd0);
                chk("rst_req_ready", 32'(req_ready), 32'd0);
                chk("rst_inflight", 32'(inflight), 32'd0);
                chk("rst_sq_ce", 32'(sq_ce), 32'd1);
                mq.delete();
                ptr   = 0;
                taken = '0;
            end else begin
                present = mq.size() > 0 && mq[0].age >= L;
                own     = present ? mq[0].owner : 0;
                exp_rv  = present ? N'(1 << own) : '0;
                exp_ce  = !(present && !res_ready[own]);
                gnt     = -1;
                if (exp_ce)
                    for (int k = 0; k < N; k++)
                        if (gnt < 0 && req_valid[(ptr + k) % N]) gnt = (ptr + k) % N;
                exp_rr = (gnt >= 0) ? N'(1 << gnt) : '0;
                exp_in = (gnt >= 0) ? req_data[32*gnt +: 32] : 32'd0;
                chk("sq_ce", 32'(sq_ce), 32'(exp_ce));
                chk("req_ready", 32'(req_ready), 32'(exp_rr));
                chk("sq_data_in", sq_data_in, exp_in);
                chk("res_valid", 32'(res_valid), 32'(exp_rv));
                if (present) chk("res_data", res_data, mq[0].data);
                chk("inflight", 32'(inflight), 32'(mq.size()));
                chk("idle", 32'(idle), 32'(mq.size() == 0 && req_valid == '0));
                taken = req_valid & req_ready;
                for (int i = 0; i < N; i++)
                    if (taken[i]) begin
                        g_cyc.push_back(cyc);
                        g_own.push_back(i);
                    end
                if (|(res_valid & res_ready)) begin
                    r_cyc.push_back(cyc);
                    r_dat.push_back(res_data);
                end
                if (exp_ce) begin
                    if (present && res_ready[own]) void'(mq.pop_front());
                    foreach (mq[q]) mq[q].age++;
                    if (gnt >= 0) begin
                        mq.push_back('{owner: gnt, data: req_data[32*gnt +: 32] + 32'd1, age: 1});
                        ptr = (gnt + 1) % N;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (taken[i]) req_valid[i] = 1'b0;
            if (auto_on && !req_valid[i] && $urandom_range(99) < p_req) begin
                req_valid[i]          = 1'b1;
                req_data[32*i +: 32]  = $urandom;
            end
            res_ready[i] = ($urandom_range(99) < p_rdy) && !mask[i];
        end
    endtask

    task automatic clear_logs();
        g_cyc.delete();
        g_own.delete();
        r_cyc.delete();
        r_dat.delete();
    endtask

    initial begin
        int s0;
        req_valid = '0;
        req_data  = '0;
        res_ready = '1;
        fork
            monitor();
        join_none
        repeat (3) step();
        rst = 1'b0;

        clear_logs();
        req_data[64 +: 32] = 32'h4080_0000;
        req_valid[2]       = 1'b1;
        repeat (12) step();
        chk("single_grants", 32'(g_cyc.size()), 32'd1);
        chk("single_results", 32'(r_cyc.size()), 32'd1);
        if (g_cyc.size() == 1 && r_cyc.size() == 1) begin
            chk("single_latency", 32'(r_cyc[0] - g_cyc[0]), 32'd8);
            chk("single_data", r_dat[0], 32'h4080_0001);
        end
        chk("single_inflight", 32'(inflight), 32'd0);

        clear_logs();
        auto_on = 1'b1;
        p_req   = 100;
        repeat (30) step();
        auto_on = 1'b0;
        if (g_own.size() >= 8)
            for (int k = 0; k < 8; k++) chk("rr_order", 32'(g_own[k]), 32'((3 + k) % N));
        else
            chk("rr_grant_count", 32'(g_own.size()), 32'd8);
        if (r_cyc.size() >= 6)
            for (int k = 0; k < 5; k++) chk("one_per_cycle", 32'(r_cyc[k+1] - r_cyc[k]), 32'd1);
        else
            chk("result_count", 32'(r_cyc.size()), 32'd6);
        repeat (15) step();

        clear_logs();
        auto_on = 1'b1;
        for (int w = 0; w < 40 && !res_valid[1]; w++) step();
        chk("stall_found", 32'(res_valid[1]), 32'd1);
        res_ready[1] = 1'b0;
        s0   = stall_cnt;
        mask = 4'b0010;
        repeat (4) step();
        mask = '0;
        step();
        chk("stall_cycles", 32'(stall_cnt - s0), 32'd5);
        auto_on = 1'b0;
        repeat (20) step();
        chk("stall_no_loss", 32'(r_cyc.size()), 32'(g_cyc.size()));

        clear_logs();
        req_valid[0]       = 1'b1;
        req_data[0 +: 32]  = $urandom;
        repeat (3) step();
        req_valid[1]       = 1'b1;
        req_data[32 +: 32] = $urandom;
        repeat (12) step();
        chk("bubble_results", 32'(r_cyc.size()), 32'd2);
        if (g_cyc.size() == 2 && r_cyc.size() == 2) begin
            chk("bubble_grant_gap", 32'(g_cyc[1] - g_cyc[0]), 32'd3);
            chk("bubble_first", 32'(r_cyc[0] - g_cyc[0]), 32'd8);
            chk("bubble_result_gap", 32'(r_cyc[1] - r_cyc[0]), 32'd3);
        end

        auto_on = 1'b1;
        repeat (4) step();
        chk("pre_rst_inflight", 32'(inflight), 32'd3);
        rst       = 1'b1;
        auto_on   = 1'b0;
        req_valid = '0;
        step();
        rst = 1'b0;
        clear_logs();
        repeat (12) step();
        chk("rst_no_results", 32'(r_cyc.size()), 32'd0);
        req_valid          = 4'b1001;
        req_data[0 +: 32]  = 32'h3f80_0000;
        req_data[96 +: 32] = 32'h4100_0000;
        repeat (3) step();
        chk("rst_grants", 32'(g_own.size()), 32'd2);
        if (g_own.size() == 2) begin
            chk("rst_first_grant", 32'(g_own[0]), 32'd0);
            chk("rst_second_grant", 32'(g_own[1]), 32'd3);
        end
        repeat (12) step();

        clear_logs();
        auto_on = 1'b1;
        p_req   = 40;
        p_rdy   = 60;
        repeat (1500) step();
        auto_on = 1'b0;
        p_rdy   = 100;
        for (int w = 0; w < 300 && !(idle && inflight == 4'd0); w++) step();
        chk("drain_idle", 32'(idle), 32'd1);
        chk("drain_balance", 32'(r_cyc.size()), 32'(g_cyc.size()));

`ifdef INVSQ_SCHED_CHECK_EN
        auto_on = 1'b1;
        p_req   = 100;
        for (int w = 0; w < 40 && res_valid == '0; w++) step();
        chk("err_found_result", 32'(res_valid != '0), 32'd1);
        chk("err_initial", 32'(err), 32'd0);
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        repeat (5) step();
        chk("err_sticky", 32'(err), 32'd1);
        auto_on   = 1'b0;
        rst       = 1'b1;
        req_valid = '0;
        #1;
        chk("err_cleared", 32'(err), 32'd0);
        step();
        rst = 1'b0;
        repeat (2) step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
